sigma_delta_mod_tx: RTL and testbench

- Second-order 1-bit sigma-delta modulator. It is the transmit-side counterpart of the team's sinc3 decimator.
- Accepts 16-bit unsigned density words through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Holds each word for one frame of dec_rate bit clocks and emits one bitstream bit per clock on mdata1.
- Word coding matches the decimator's DATA output: 0x0000 = all zeros, 0x8000 = 50 % ones, 0xFFFF = all ones.

---
 rtl/sigma_delta_pkg.sv | 32 +++
 rtl/sd_tx_fifo2.sv | 50 +++++
 rtl/sigma_delta_mod_tx.sv | 116 +++++++++++
 tb/tb_sigma_delta_mod_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared constants, state type and helpers for the sigma-delta transmitter
package sigma_delta_pkg;

    localparam int          INT_W_DEF   = 22;
    localparam logic [15:0] DEC_DEFAULT = 16'd256;
    localparam logic [15:0] MIDSCALE    = 16'h8000;
    localparam longint      FB_POS      = 64'sd32768;
    localparam longint      FB_NEG      = -64'sd32768;

    typedef enum logic {IDLE, RUN} sd_state_t;

    // Frame lengths the decimator supports; anything else falls back to the default.
    function automatic logic [15:0] legal_rate(input logic [15:0] r);
        case (r)
            16'd32, 16'd64, 16'd128, 16'd256,
            16'd512, 16'd1024, 16'd2048, 16'd4096: return r;
            default:                               return DEC_DEFAULT;
        endcase
    endfunction

    // Sum computed wide enough that it never wraps, then clamped to +/-(2^(w-1)-1).
    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint lim;
        longint s;
        lim = (longint'(1) <<< (w - 1)) - 1;
        s   = a + b;
        if (s > lim)  return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/sd_tx_fifo2.sv
// rtl/sd_tx_fifo2.sv - two-entry synchronous FIFO buffering density words
module sd_tx_fifo2 #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         mclk1,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge mclk1) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge mclk1) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ do_push;
            rd_ptr <= rd_ptr ^ do_pop;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigma_delta_mod_tx.sv
// rtl/sigma_delta_mod_tx.sv - second-order 1-bit sigma-delta modulator fed by a framed word FIFO
module sigma_delta_mod_tx
    import sigma_delta_pkg::*;
#(
    parameter int INT_W      = INT_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        mclk1,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [15:0] dec_rate,
    output logic        mdata1,
    output logic        sample_strobe,
    output logic        underrun
);
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    load;
    logic                    underrun_set;
    logic                    boundary;
    logic [15:0]             fifo_rdata;
    logic [15:0]             rate;
    logic [15:0]             word_count;
    logic [15:0]             held;
    sd_state_t               state;
    sd_state_t               state_nxt;
    logic signed [15:0]      x;
    longint                  fb;
    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;
    logic signed [INT_W-1:0] i1_nxt;
    logic signed [INT_W-1:0] i2_nxt;

    assign din_ready = !fifo_full;
    assign push      = din_valid && !fifo_full;
    assign boundary  = (word_count == rate - 16'd1);

    sd_tx_fifo2 #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .mclk1 (mclk1),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .wdata (din),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge mclk1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Words are only taken at the last bit of a frame so each frame carries one value.
    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        underrun_set = 1'b0;
        if (boundary) begin
            if (!fifo_empty) begin
                load      = 1'b1;
                state_nxt = RUN;
            end else if (state == RUN) begin
                underrun_set = 1'b1;
            end
        end
    end

    // Offset-binary word to two's complement; feedback uses the bit already on the wire.
    always_comb begin
        x      = {~held[15], held[14:0]};
        fb     = mdata1 ? FB_POS : FB_NEG;
        i1_nxt = INT_W'(sat_add(longint'(i1), longint'(x) - fb, INT_W));
        i2_nxt = INT_W'(sat_add(longint'(i2), longint'(i1) - fb, INT_W));
    end

    always_ff @(posedge mclk1) begin
        if (reset) begin
            word_count    <= '0;
            rate          <= legal_rate(dec_rate);
            held          <= MIDSCALE;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
            mdata1        <= 1'b0;
            i1            <= '0;
            i2            <= '0;
        end else begin
            sample_strobe <= load;
            if (load) begin
                held <= fifo_rdata;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end
            if (boundary) begin
                word_count <= '0;
                rate       <= legal_rate(dec_rate);
            end else begin
                word_count <= word_count + 16'd1;
            end
            i1     <= i1_nxt;
            i2     <= i2_nxt;
            mdata1 <= ~i2_nxt[INT_W-1];
        end
    end

endmodule

// File: tb/tb_sigma_delta_mod_tx.sv
// tb/tb_sigma_delta_mod_tx.sv - self-checking bench for sigma_delta_mod_tx
module tb_sigma_delta_mod_tx;

    logic        mclk1 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic [15:0] dec_rate = 16'd256;
    logic        din_ready;
    logic        mdata1;
    logic        sample_strobe;
    logic        underrun;

    sigma_delta_mod_tx dut (
        .mclk1         (mclk1),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dec_rate      (dec_rate),
        .mdata1        (mdata1),
        .sample_strobe (sample_strobe),
        .underrun      (underrun)
    );

    always #5 mclk1 = ~mclk1;

    localparam int LIM = (1 << 21) - 1;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mq[$];
    int          m_wc, m_r, m_frames, m_loads, ones_acc, last_ones, cyc;
    bit          m_run, m_uf, sat_ok;
    longint      ci1, ci2, ci3, cp3, pd1, pd2, dec_val;
    int          strobe_t[$];

    function automatic int legal(input int v);
        return (v >= 32 && v <= 4096 && (v & (v - 1)) == 0) ? v : 256;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One bit clock: check ready against the queue, advance the frame model, feed the sinc3 model.
    task automatic cycle();
        bit     bnd, pop, psh;
        longint d1, d2, d3;
        chk("din_ready", din_ready, mq.size() < 2);
        psh = din_valid && (mq.size() < 2);
        bnd = (m_wc == m_r - 1);
        pop = bnd && (mq.size() > 0);
        @(posedge mclk1);
        #1;
        cyc++;
        ones_acc += mdata1;
        ci1 += mdata1;
        ci2 += ci1;
        ci3 += ci2;
        if (bnd) begin
            last_ones = ones_acc;
            ones_acc  = 0;
            m_frames++;
            d1  = ci3 - cp3;
            cp3 = ci3;
            d2  = d1 - pd1;
            pd1 = d1;
            d3  = d2 - pd2;
            pd2 = d2;
            dec_val = (d3 * 65536) / (longint'(m_r) * m_r * m_r);
            if (dec_val > 65535) dec_val = 65535;
            m_wc = 0;
            m_r  = legal(int'(dec_rate));
            if (pop) begin
                void'(mq.pop_front());
                m_run = 1'b1;
                m_loads++;
            end else if (m_run) begin
                m_uf = 1'b1;
            end
        end else begin
            m_wc++;
        end
        if (psh) mq.push_back(din);
        if (sample_strobe) strobe_t.push_back(cyc);
        chk("sample_strobe", sample_strobe, pop);
        chk("underrun", underrun, m_uf);
        if (int'(dut.i1) > LIM || int'(dut.i1) < -LIM || int'(dut.i2) > LIM || int'(dut.i2) < -LIM)
            sat_ok = 1'b0;
        @(negedge mclk1);
    endtask

    task automatic apply_reset(input int r);
        @(negedge mclk1);
        reset     = 1'b1;
        din_valid = 1'b0;
        dec_rate  = 16'(r);
        repeat (3) @(posedge mclk1);
        @(negedge mclk1);
        chk("rst_mdata1", mdata1, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_strobe", sample_strobe, 0);
        reset = 1'b0;
        mq.delete();
        m_wc = 0; m_r = legal(r); m_run = 1'b0; m_uf = 1'b0;
        ones_acc = 0; ci1 = 0; ci2 = 0; ci3 = 0; cp3 = 0; pd1 = 0; pd2 = 0;
    endtask

    task automatic push_word(input logic [15:0] w);
        bit acc;
        din       = w;
        din_valid = 1'b1;
        acc       = 1'b0;
        for (int k = 0; k < 10000 && !acc; k++) begin
            acc = (mq.size() < 2);
            cycle();
        end
        din_valid = 1'b0;
        if (!acc) chk("push_timeout", acc, 1);
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = m_frames + n;
        for (int k = 0; k < n * 4200 && m_frames < t; k++) cycle();
        if (m_frames < t) chk("frame_timeout", m_frames, t);
    endtask

    task automatic wait_loads(input int n);
        int t;
        t = m_loads + n;
        for (int k = 0; k < n * 4200 + 4200 && m_loads < t; k++) cycle();
        if (m_loads < t) chk("load_timeout", m_loads, t);
    endtask

    task automatic wait_strobes(input int n);
        int t;
        t = strobe_t.size() + n;
        for (int k = 0; k < n * 4200 + 4200 && strobe_t.size() < t; k++) cycle();
        if (strobe_t.size() < t) chk("strobe_timeout", strobe_t.size(), t);
    endtask

    // Push a word and check the sinc3 reconstruction from the 4th frame onward.
    task automatic loop_word(input logic [15:0] w, input int nframes);
        push_word(w);
        wait_loads(1);
        for (int f = 1; f <= nframes; f++) begin
            wait_frames(1);
            if (f >= 4) chk_rng("loopback", dec_val, longint'(w) - 64, longint'(w) + 64);
        end
    endtask

    initial begin
        int s0;
        sat_ok = 1'b1; m_frames = 0; m_loads = 0; cyc = 0; last_ones = 0; dec_val = 0;

        apply_reset(256);
        wait_frames(1);
        chk_rng("idle_density", last_ones, 127, 129);

        push_word(16'h8000);
        wait_loads(1);
        wait_frames(2);
        chk_rng("mid_density", last_ones, 127, 129);
        push_word(16'hC000);
        wait_loads(1);
        wait_frames(3);
        chk_rng("c000_density", last_ones, 190, 194);
        wait_frames(1);
        chk_rng("c000_density2", last_ones, 190, 194);
        push_word(16'h4000);
        wait_loads(1);
        wait_frames(3);
        chk_rng("4000_density", last_ones, 62, 66);

        apply_reset(64);
        push_word(16'h0000);
        wait_loads(1);
        wait_frames(3);
        chk_rng("zero_density", last_ones, 0, 1);
        wait_frames(1);
        chk_rng("zero_density2", last_ones, 0, 1);
        push_word(16'hFFFF);
        wait_loads(1);
        wait_frames(3);
        chk_rng("full_density", last_ones, 63, 64);
        wait_frames(1);
        chk_rng("full_density2", last_ones, 63, 64);
        chk("saturation_bound", sat_ok, 1);

        apply_reset(256);
        repeat (20) cycle();
        din_valid = 1'b1;
        din = 16'h4000; cycle();
        din = 16'hC000; cycle();
        din = 16'h1111;
        repeat (5) cycle();
        chk("ready_when_full", din_ready, 0);
        din_valid = 1'b0;
        wait_loads(1);
        chk("ready_after_pop", din_ready, 1);
        wait_frames(1);
        chk_rng("order_first", last_ones, 40, 90);
        wait_frames(1);
        chk_rng("order_second", last_ones, 170, 215);

        push_word(16'h1234);
        push_word(16'h5678);
        apply_reset(256);
        wait_frames(2);
        chk("flush_ready", din_ready, 1);

        push_word(16'hA000);
        wait_loads(1);
        chk("no_underrun_yet", underrun, 0);
        wait_frames(1);
        chk("underrun_set", underrun, 1);
        wait_frames(2);
        chk_rng("held_after_underrun", last_ones, 158, 162);
        push_word(16'h2000);
        wait_loads(1);
        chk("underrun_sticky", underrun, 1);

        repeat (100) cycle();
        dec_rate = 16'd1000;
        push_word(16'h2000);
        push_word(16'h2000);
        s0 = strobe_t.size();
        wait_strobes(2);
        chk("len_illegal", strobe_t[s0+1] - strobe_t[s0], 256);
        repeat (50) cycle();
        dec_rate = 16'd64;
        push_word(16'h6000);
        push_word(16'h6000);
        wait_strobes(2);
        chk("len_current", strobe_t[s0+2] - strobe_t[s0+1], 256);
        chk("len_next", strobe_t[s0+3] - strobe_t[s0+2], 64);

        apply_reset(256);
        loop_word(16'h3000, 8);
        loop_word(16'hA000, 8);
        loop_word(16'hE000, 8);
        for (int k = 0; k < 4; k++) loop_word(16'($urandom_range(16'h1000, 16'hF000)), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
